// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
//
// Purpose:
//   Deserialises a frame of DATA_BITS data bits (LSB first) followed by one
//   parity bit. The data bits are XOR-accumulated, and the parity bit is
//   checked against the accumulated value. Each completed frame produces a
//   one-cycle out_valid pulse, the recovered word and a parity verdict. A
//   saturating counter records how many frames failed the parity check.
//
// Parameters:
//   DATA_BITS   data bits per frame (>= 1), excluding the parity bit
//   ODD_PARITY  0 = even parity expected, 1 = odd parity expected
//   CNT_W       width of the saturating parity-error counter
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   in_valid     in   in_bit / in_start are valid this cycle
//   in_bit       in   serial bit
//   in_start     in   marks in_bit as data bit 0 of a new frame
//   busy         out  a frame is in progress (DATA or PARITY state)
//   out_valid    out  one-cycle pulse when a frame completes
//   out_data     out  recovered word, held until the next completion
//   out_par_err  out  parity verdict for out_data, held with it
//   err_count    out  saturating count of frames with a parity error
// -----------------------------------------------------------------------------
module serial_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 in_start,
  output logic                 busy,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_par_err,
  output logic [CNT_W-1:0]     err_count
);

  // Bit counter must be able to hold the values 0..DATA_BITS-1.
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_acc;
  logic [DATA_BITS-1:0] r_word;
  logic                 r_busy;
  logic                 r_out_valid;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_par_err;
  logic [CNT_W-1:0]     r_err_count;

  // Parity verdict for the bit being presented in the PARITY state.
  logic w_err;
  // Current data bit shifted to its final position in the word.
  logic [DATA_BITS-1:0] w_bit_in_place;
  // True when the data bit being accepted is the last one of the frame.
  logic w_last_data;

  assign w_err          = r_acc ^ in_bit ^ ODD_PARITY;
  assign w_bit_in_place = DATA_BITS'(in_bit) << r_cnt;
  assign w_last_data    = (r_cnt == CW'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register, including the word
    // buffer, is cleared so a partial frame can never leak out.
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_acc         <= 1'b0;
      r_word        <= '0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_par_err <= 1'b0;
      r_err_count   <= '0;
    end else begin
      // NOTE: out_valid defaults low every cycle so it can only ever be a
      // single-cycle pulse; the completion branch below overrides it.
      r_out_valid <= 1'b0;

      if (in_valid) begin
        if (in_start) begin
          // A start bit is honoured in any state: it begins a fresh frame
          // and silently discards whatever partial frame was in flight.
          r_acc  <= in_bit;
          r_word <= DATA_BITS'(in_bit);
          r_cnt  <= CW'(1 % DATA_BITS);
          r_busy <= 1'b1;
          if (DATA_BITS == 1) begin
            r_state <= ST_PARITY;
          end else begin
            r_state <= ST_DATA;
          end
        end else begin
          unique case (r_state)
            ST_IDLE: begin
              // Stray bits without a start marker are ignored.
            end

            ST_DATA: begin
              r_acc  <= r_acc ^ in_bit;
              r_word <= r_word | w_bit_in_place;
              if (w_last_data) begin
                r_cnt   <= '0;
                r_state <= ST_PARITY;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end

            ST_PARITY: begin
              r_state       <= ST_IDLE;
              r_busy        <= 1'b0;
              r_out_valid   <= 1'b1;
              r_out_data    <= r_word;
              r_out_par_err <= w_err;
              // Saturate rather than wrap so a long error burst never
              // reads back as a small count.
              if (w_err && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
              end
            end

            default: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign busy        = r_busy;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_par_err = r_out_par_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_serial_parity_checker.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_checker
//
// Four checker instances share one serial stream; a select mask gates
// in_valid so each directed step talks to the intended configuration:
//   0: DATA_BITS=8, even, CNT_W=8
//   1: DATA_BITS=8, odd,  CNT_W=8
//   2: DATA_BITS=8, even, CNT_W=2   (saturation)
//   3: DATA_BITS=1, even, CNT_W=8
// Expected results come from the frame contents: the word is the data bits,
// the verdict is XOR-reduce(data) ^ parity ^ odd, and the error count is a
// saturating tally of verdicts.
// -----------------------------------------------------------------------------
module tb_serial_parity_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_start = 1'b0;
  logic [3:0] sel = 4'b0000;
  logic [3:0] iv;

  logic [3:0] ov, pe, bz;
  logic [7:0] od0, od1, od2, ec0, ec1, ec3;
  logic [0:0] od3;
  logic [1:0] ec2;
  logic [7:0] od [4];
  logic [7:0] ec [4];

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt [4];
  int n_ov [4];
  int exp_nov [4];

  localparam bit [3:0] ODD     = 4'b0010;
  localparam int       MAXC[4] = '{255, 255, 3, 255};
  localparam int       NB[4]   = '{8, 8, 8, 1};

  always #5 clk = ~clk;

  assign iv = {4{in_valid}} & sel;

  always_comb begin
    od[0] = od0; od[1] = od1; od[2] = od2; od[3] = {7'b0, od3};
    ec[0] = ec0; ec[1] = ec1; ec[2] = {6'b0, ec2}; ec[3] = ec3;
  end

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b0), .CNT_W(8)) u_even (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_bit(in_bit), .in_start(in_start),
    .busy(bz[0]), .out_valid(ov[0]), .out_data(od0), .out_par_err(pe[0]), .err_count(ec0));
  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b1), .CNT_W(8)) u_odd (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_bit(in_bit), .in_start(in_start),
    .busy(bz[1]), .out_valid(ov[1]), .out_data(od1), .out_par_err(pe[1]), .err_count(ec1));
  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_bit(in_bit), .in_start(in_start),
    .busy(bz[2]), .out_valid(ov[2]), .out_data(od2), .out_par_err(pe[2]), .err_count(ec2));
  serial_parity_checker #(.DATA_BITS(1), .ODD_PARITY(1'b0), .CNT_W(8)) u_one (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_bit(in_bit), .in_start(in_start),
    .busy(bz[3]), .out_valid(ov[3]), .out_data(od3), .out_par_err(pe[3]), .err_count(ec3));

  // Count out_valid pulses away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (ov[k] === 1'b1) n_ov[k]++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, k, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input bit gaps);
    int r;
    if (!gaps) return;
    r = $urandom_range(0, 2);
    in_valid = 1'b0;
    for (int i = 0; i < r; i++) begin
      in_bit   = 1'($urandom);
      in_start = 1'($urandom);
      step();
    end
  endtask

  task automatic check_idle_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_busy"}, k, 32'(bz[k]), 32'd0);
      check({tag, "_ov"},   k, 32'(ov[k]), 32'd0);
      check({tag, "_data"}, k, 32'(od[k]), 32'd0);
      check({tag, "_err"},  k, 32'(pe[k]), 32'd0);
      check({tag, "_cnt"},  k, 32'(ec[k]), 32'd0);
    end
  endtask

  // Data bits only; the first carries in_start.
  task automatic send_bits(input logic [7:0] data, input int n, input bit gaps);
    logic [7:0] d;
    d = data;
    for (int i = 0; i < n; i++) begin
      gap(gaps);
      in_valid = 1'b1;
      in_bit   = d[i];
      in_start = (i == 0);
      step();
      if (i == 0) begin
        for (int k = 0; k < 4; k++) if (sel[k]) begin
          check("start_busy", k, 32'(bz[k]), 32'd1);
          check("start_ov",   k, 32'(ov[k]), 32'd0);
        end
      end
    end
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send_parity(input logic par, input bit gaps);
    gap(gaps);
    in_valid = 1'b1;
    in_bit   = par;
    in_start = 1'b0;
    step();
    in_valid = 1'b0;
  endtask

  // Checks the completion cycle for every selected instance.
  task automatic expect_done(input logic [7:0] data, input logic par);
    logic [7:0] w;
    logic       e;
    for (int k = 0; k < 4; k++) if (sel[k]) begin
      w = (NB[k] == 8) ? data : {7'b0, data[0]};
      e = (^w) ^ par ^ ODD[k];
      if (e && exp_cnt[k] < MAXC[k]) exp_cnt[k]++;
      exp_nov[k]++;
      check("ov",   k, 32'(ov[k]), 32'd1);
      check("data", k, 32'(od[k]), 32'(w));
      check("err",  k, 32'(pe[k]), 32'(e));
      check("cnt",  k, 32'(ec[k]), 32'(exp_cnt[k]));
      check("busy", k, 32'(bz[k]), 32'd0);
    end
  endtask

  task automatic frame(input logic [7:0] data, input logic par, input bit gaps);
    send_bits(data, (sel == 4'b1000) ? 1 : 8, gaps);
    send_parity(par, gaps);
    expect_done(data, par);
  endtask

  task automatic check_pulses(input string tag);
    step();
    for (int k = 0; k < 4; k++) check(tag, k, 32'(n_ov[k]), 32'(exp_nov[k]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      exp_cnt[k] = 0; n_ov[k] = 0; exp_nov[k] = 0;
    end

    // Reset state
    do_reset();
    check_idle_zero("reset");

    // 1: even, 0xA5 + parity 0
    sel = 4'b0001;
    frame(8'hA5, 1'b0, 1'b0);
    step();
    check("ov_pulse_width", 0, 32'(ov[0]), 32'd0);

    // 2: 0x07 + parity 0 (error), then back-to-back 0x07 + parity 1
    frame(8'h07, 1'b0, 1'b0);
    frame(8'h07, 1'b1, 1'b0);
    check_pulses("pulses_t2");

    // 3: odd parity
    sel = 4'b0010;
    frame(8'h00, 1'b1, 1'b0);
    frame(8'h00, 1'b0, 1'b0);

    // 4: abort after 4 bits of 0xFF, restart with 0x3C; then with gaps
    sel = 4'b0001;
    send_bits(8'hFF, 4, 1'b0);
    frame(8'h3C, 1'b0, 1'b0);
    check_pulses("pulses_abort");
    send_bits(8'hFF, 4, 1'b1);
    frame(8'h3C, 1'b0, 1'b1);
    check_pulses("pulses_abort_gaps");

    // 5: reset mid-frame, stray bits in IDLE, then a clean frame
    send_bits(8'h5A, 5, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    check_idle_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_start = 1'b0; in_bit = 1'($urandom);
      step();
      check("stray_busy", 0, 32'(bz[0]), 32'd0);
    end
    in_valid = 1'b0;
    check_pulses("pulses_rst");
    frame(8'h81, 1'b0, 1'b0);

    // 6: saturation with CNT_W=2, then DATA_BITS=1
    sel = 4'b0100;
    for (int i = 0; i < 5; i++) frame(8'h01, 1'b0, 1'($urandom));
    sel = 4'b1000;
    frame(8'h01, 1'b1, 1'b0);
    frame(8'h01, 1'b0, 1'b0);
    frame(8'h00, 1'b0, 1'b1);
    check_pulses("pulses_t6");

    // Random frames on all three 8-bit instances, with gaps and aborts
    sel = 4'b0111;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) send_bits(8'($urandom), $urandom_range(1, 7), 1'($urandom));
      frame(8'($urandom), 1'($urandom), 1'($urandom));
    end
    check_pulses("pulses_rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
